// File: rtl/image_window_ctrl_if.sv
// Command/pixel bus for image_window_ctrl.
//   cmd, cmd_valid : command code and strobe (master -> slave)
//   datain         : pixel stream during load (master -> slave)
//   dataout        : registered window pixel (slave -> master)
//   output_valid   : dataout qualifier (slave -> master)
//   busy           : command in progress, new commands ignored (slave -> master)
interface image_window_ctrl_if #(
   parameter int DW = 8
);
   logic [2:0]    cmd;
   logic          cmd_valid;
   logic [DW-1:0] datain;
   logic [DW-1:0] dataout;
   logic          output_valid;
   logic          busy;

   modport master (output cmd, cmd_valid, datain, input dataout, output_valid, busy);
   modport slave  (input cmd, cmd_valid, datain, output dataout, output_valid, busy);
endinterface

// File: rtl/image_window_ctrl.sv
// Image window controller: loads an IMG_W x IMG_H pixel image, then emits a
// WIN_W x WIN_H window either subsampled over the whole image (FIT) or as a
// 1:1 crop at a movable origin (ZOOM).
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : command / pixel interface (slave side)
module image_window_ctrl #(
   parameter int DW    = 8,
   parameter int IMG_W = 12,
   parameter int IMG_H = 9,
   parameter int WIN_W = 4,
   parameter int WIN_H = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   image_window_ctrl_if.slave   bus
);

   localparam int N     = IMG_W * IMG_H;
   localparam int AW    = (N > 1) ? $clog2(N) : 1;
   localparam int OX0   = (IMG_W - WIN_W + 1) / 2;
   localparam int OY0   = (IMG_H - WIN_H + 1) / 2;
   localparam int OXMAX = IMG_W - WIN_W;
   localparam int OYMAX = IMG_H - WIN_H;
   localparam int SX    = IMG_W / WIN_W;
   localparam int SY    = IMG_H / WIN_H;

   localparam logic [2:0] CMD_LOAD  = 3'd0;
   localparam logic [2:0] CMD_ZOOM  = 3'd1;
   localparam logic [2:0] CMD_FIT   = 3'd2;
   localparam logic [2:0] CMD_RIGHT = 3'd3;
   localparam logic [2:0] CMD_LEFT  = 3'd4;
   localparam logic [2:0] CMD_UP    = 3'd5;
   localparam logic [2:0] CMD_DOWN  = 3'd6;
   localparam logic [2:0] CMD_CTR   = 3'd7;

   typedef enum logic [1:0] {IDLE, LOAD, PREP, OUT} state_t;
   typedef enum logic {M_FIT, M_ZOOM} mode_t;

   state_t        state_q, state_d;
   mode_t         mode_q, mode_d;
   logic [AW-1:0] ox_q, ox_d, oy_q, oy_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] row_q, row_d, col_q, col_d;
   logic [DW-1:0] dataout_q, dataout_d;
   logic          ov_q, ov_d;
   logic          busy_q, busy_d;
   logic [DW-1:0] mem_q [N];

   logic          accept, load_last, out_last;
   logic [AW-1:0] row_idx, col_idx, rd_addr;

   // busy_q low implies IDLE, so it alone gates acceptance.
   assign accept    = bus.cmd_valid & ~busy_q;
   assign load_last = (cnt_q == AW'(N - 1));
   assign out_last  = (row_q == AW'(WIN_H - 1)) && (col_q == AW'(WIN_W - 1));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         mode_q    <= M_FIT;
         ox_q      <= AW'(OX0);
         oy_q      <= AW'(OY0);
         cnt_q     <= '0;
         row_q     <= '0;
         col_q     <= '0;
         dataout_q <= '0;
         ov_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         ox_q      <= ox_d;
         oy_q      <= oy_d;
         cnt_q     <= cnt_d;
         row_q     <= row_d;
         col_q     <= col_d;
         dataout_q <= dataout_d;
         ov_q      <= ov_d;
         busy_q    <= busy_d;
      end
   end

   // Pixel store is deliberately not reset; reset parks the FSM in IDLE,
   // which stops any write in flight.
   always_ff @(posedge clk) begin
      if (state_q == LOAD) mem_q[cnt_q] <= bus.datain;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = (bus.cmd == CMD_LOAD) ? LOAD : PREP;
         LOAD: if (load_last) state_d = PREP;
         PREP: state_d = OUT;
         OUT:  if (out_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath / outputs
   always_comb begin
      mode_d = mode_q;
      ox_d   = ox_q;
      oy_d   = oy_q;
      cnt_d  = cnt_q;
      row_d  = row_q;
      col_d  = col_q;

      // Source coordinate of window pixel (row_q, col_q); both paths stay
      // inside the image so the address never exceeds N-1.
      if (mode_q == M_ZOOM) begin
         row_idx = oy_q + row_q;
         col_idx = ox_q + col_q;
      end else begin
         row_idx = row_q * AW'(SY) + AW'(SY / 2);
         col_idx = col_q * AW'(SX) + AW'(SX / 2);
      end
      rd_addr = row_idx * AW'(IMG_W) + col_idx;

      // Each OUT cycle registers one pixel; busy covers that final
      // registered pixel so it drops together with output_valid.
      ov_d      = (state_q == OUT);
      dataout_d = ov_d ? mem_q[rd_addr] : dataout_q;
      busy_d    = (state_d != IDLE) || ov_d;

      if (state_q == LOAD) begin
         cnt_d = load_last ? '0 : cnt_q + 1'b1;
         if (load_last) begin
            mode_d = M_FIT;
            ox_d   = AW'(OX0);
            oy_d   = AW'(OY0);
         end
      end

      if (state_q == OUT) begin
         if (col_q == AW'(WIN_W - 1)) begin
            col_d = '0;
            row_d = out_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      if (state_q == IDLE && accept) begin
         case (bus.cmd)
            CMD_ZOOM:  mode_d = M_ZOOM;
            CMD_FIT:   mode_d = M_FIT;
            CMD_RIGHT: if (mode_q == M_ZOOM && ox_q < AW'(OXMAX)) ox_d = ox_q + 1'b1;
            CMD_LEFT:  if (mode_q == M_ZOOM && ox_q != '0)        ox_d = ox_q - 1'b1;
            CMD_UP:    if (mode_q == M_ZOOM && oy_q != '0)        oy_d = oy_q - 1'b1;
            CMD_DOWN:  if (mode_q == M_ZOOM && oy_q < AW'(OYMAX)) oy_d = oy_q + 1'b1;
            CMD_CTR: begin
               ox_d = AW'(OX0);
               oy_d = AW'(OY0);
            end
            default: ;
         endcase
      end
   end

   assign bus.dataout      = dataout_q;
   assign bus.output_valid = ov_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_image_window_ctrl.sv
// Directed bench for image_window_ctrl at default geometry (12x9 image,
// 4x4 window, DW=8), image loaded with pixel k = k.
module tb_image_window_ctrl;
   localparam int DW = 8, IMG_W = 12, IMG_H = 9, WIN_W = 4, WIN_H = 4;
   localparam int N = IMG_W * IMG_H;

   logic clk = 1'b0;
   logic reset = 1'b0;

   image_window_ctrl_if #(.DW(DW)) bus ();

   image_window_ctrl #(
      .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN_W(WIN_W), .WIN_H(WIN_H)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] cmd;
      bit         fit;
      int         base;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int exp_px [16];
   int fit_px [16] = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
   vec_t vecs [33];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic set_exp(input bit fit, input int base);
      for (int i = 0; i < 16; i++)
         exp_px[i] = fit ? fit_px[i] : base + (i / 4) * IMG_W + (i % 4);
   endtask

   // Issue one command and check every cycle up to busy falling.
   // lat: edges from accept to first valid pixel. inject_at: cycle to pulse
   // a cmd 6 while busy. abort_at: cycle at which reset is asserted.
   task automatic run_cmd(input logic [2:0] c, input int lat, input int inject_at,
                          input int abort_at, input string tag);
      @(negedge clk);
      bus.cmd = c;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.datain = '0;
      chk({tag, " busy_rise"}, 32'(bus.busy), 1);
      for (int i = 1; i <= lat + 15; i++) begin
         @(posedge clk); #1;
         if (c == 3'd0 && i < N) bus.datain = DW'(i);
         bus.cmd_valid = 1'b0;
         if (i == inject_at) begin
            bus.cmd = 3'd6;
            bus.cmd_valid = 1'b1;
         end
         if (i < lat) begin
            chk($sformatf("%s ov_low_c%0d", tag, i), 32'(bus.output_valid), 0);
            chk($sformatf("%s busy_c%0d", tag, i), 32'(bus.busy), 1);
         end else begin
            chk($sformatf("%s ov_px%0d", tag, i - lat), 32'(bus.output_valid), 1);
            chk($sformatf("%s px%0d", tag, i - lat), 32'(bus.dataout), exp_px[i - lat]);
            chk($sformatf("%s busy_px%0d", tag, i - lat), 32'(bus.busy), 1);
         end
         if (i == abort_at) begin
            reset = 1'b0;
            #1;
            chk({tag, " abort_ov"}, 32'(bus.output_valid), 0);
            chk({tag, " abort_busy"}, 32'(bus.busy), 0);
            chk({tag, " abort_data"}, 32'(bus.dataout), 0);
            return;
         end
      end
      @(posedge clk); #1;
      chk({tag, " ov_fall"}, 32'(bus.output_valid), 0);
      chk({tag, " busy_fall"}, 32'(bus.busy), 0);
      chk({tag, " data_hold"}, 32'(bus.dataout), exp_px[15]);
   endtask

   initial begin
      bus.cmd = 3'd0;
      bus.cmd_valid = 1'b0;
      bus.datain = '0;

      // ZOOM walk from centre (4,3): saturation on each edge, recenter,
      // FIT shifts leave origin alone, recenter keeps mode.
      vecs[0]  = '{3'd1, 1'b0, 40};
      vecs[1]  = '{3'd3, 1'b0, 41};
      vecs[2]  = '{3'd3, 1'b0, 42};
      vecs[3]  = '{3'd3, 1'b0, 43};
      vecs[4]  = '{3'd3, 1'b0, 44};
      vecs[5]  = '{3'd3, 1'b0, 44};
      vecs[6]  = '{3'd4, 1'b0, 43};
      vecs[7]  = '{3'd5, 1'b0, 31};
      vecs[8]  = '{3'd5, 1'b0, 19};
      vecs[9]  = '{3'd5, 1'b0, 7};
      vecs[10] = '{3'd5, 1'b0, 7};
      vecs[11] = '{3'd6, 1'b0, 19};
      vecs[12] = '{3'd7, 1'b0, 40};
      vecs[13] = '{3'd2, 1'b1, 0};
      vecs[14] = '{3'd3, 1'b1, 0};
      vecs[15] = '{3'd1, 1'b0, 40};
      vecs[16] = '{3'd5, 1'b0, 28};
      vecs[17] = '{3'd5, 1'b0, 16};
      vecs[18] = '{3'd5, 1'b0, 4};
      vecs[19] = '{3'd5, 1'b0, 4};
      vecs[20] = '{3'd7, 1'b0, 40};
      vecs[21] = '{3'd4, 1'b0, 39};
      vecs[22] = '{3'd4, 1'b0, 38};
      vecs[23] = '{3'd4, 1'b0, 37};
      vecs[24] = '{3'd4, 1'b0, 36};
      vecs[25] = '{3'd4, 1'b0, 36};
      vecs[26] = '{3'd6, 1'b0, 48};
      vecs[27] = '{3'd6, 1'b0, 60};
      vecs[28] = '{3'd6, 1'b0, 60};
      vecs[29] = '{3'd2, 1'b1, 0};
      vecs[30] = '{3'd7, 1'b1, 0};
      vecs[31] = '{3'd1, 1'b0, 40};
      vecs[32] = '{3'd6, 1'b0, 52};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst ov", 32'(bus.output_valid), 0);
      chk("rst busy", 32'(bus.busy), 0);
      chk("rst data", 32'(bus.dataout), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Load: first pixel valid 110 edges after acceptance
      set_exp(1'b1, 0);
      run_cmd(3'd0, N + 2, -1, -1, "load");

      foreach (vecs[i]) begin
         set_exp(vecs[i].fit, vecs[i].base);
         run_cmd(vecs[i].cmd, 2, -1, -1, $sformatf("v%0d", i));
      end

      // Command pulsed while busy is ignored: origin (4,4) stays put
      set_exp(1'b0, 52);
      run_cmd(3'd1, 2, 5, -1, "busy_ign");
      set_exp(1'b0, 52);
      run_cmd(3'd1, 2, -1, -1, "after_ign");

      // Reset at the 5th output pixel of a shift-right (origin 5,4)
      set_exp(1'b0, 53);
      run_cmd(3'd3, 2, -1, 6, "abort");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst ov%0d", i), 32'(bus.output_valid), 0);
         chk($sformatf("post_rst busy%0d", i), 32'(bus.busy), 0);
      end
      set_exp(1'b0, 40);
      run_cmd(3'd1, 2, -1, -1, "post_rst_zoom");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
